frame_tx: RTL and testbench
===========================

# frame_tx

Readback transmitter for the host byte link. It reads a contiguous range of an on-chip 8-bit memory, such as the conv1 output buffer or the input image buffer. For each word it emits one frame in the same format the host-to-FPGA command receiver accepts: sync, opcode, address low, address high, data. It sits between the layer memories and the host-side link driver and is the FPGA-to-host half of the link.

## Interface
Parameters:
- ADDR_W, 16, memory address and word-count width
- SYNC_BYTE, 8'h19, first byte of every frame
- OPCODE, 8'h07, readback opcode carried in byte 2 of every frame

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset; logic clears immediately on assertion, release is synchronous to clk
- start  in  1  single-cycle request; sampled in IDLE only
- base_addr  in  ADDR_W  first memory address; latched on start
- count  in  ADDR_W  number of words to send; latched on start
- mem_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  8  read data, valid exactly 1 cycle after mem_en
- tx_data  out  8  byte to host link
- tx_valid  out  1  tx_data holds a byte
- tx_ready  in  1  link accepts the byte
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, FETCH, WAIT, SYNC, OP, ALO, AHI, DATA, CHK (macro only), NEXT.
- IDLE, start=1, count≠0:
  - latch base_addr into cur_addr and count into remaining.
  - go to FETCH; busy=1.
- IDLE, start=1, count=0: no bytes sent, no memory read; done pulses next cycle; busy stays 0.
- FETCH: mem_en=1 and mem_addr=cur_addr for one cycle, then WAIT.
- WAIT: capture mem_data into data_reg, then SYNC.
- SYNC, OP, ALO, AHI, DATA: present SYNC_BYTE, OPCODE, cur_addr[7:0], cur_addr[15:8] and data_reg in that order. Each state advances only on tx_valid && tx_ready.
- NEXT:
  - remaining decrements and cur_addr increments modulo 2^ADDR_W, so 16'hFFFF is followed by 16'h0000.
  - if remaining reaches 0: pulse done, clear busy, go to IDLE.
  - otherwise go to FETCH.
- start while busy is ignored. base_addr and count changes after start are ignored.
- Running checksum: XOR of all bytes of the current frame, cleared in SYNC.

## Timing
- Reset values: mem_en=0, mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE.
- Start to first byte:
  - start at edge N.
  - mem_en high in cycle N+1.
  - tx_valid high with SYNC_BYTE in cycle N+3.
- With tx_ready held high, one byte per cycle.
- Frame period is 5 bytes + 3 overhead cycles (NEXT, FETCH, WAIT) = 8 cycles; 9 cycles with the checksum byte.
- tx_valid is registered and never drops while tx_ready=0. tx_data is held stable until accepted.
- done asserts in the cycle after the final DATA (or CHK) byte is accepted.
- reset asserted mid-frame: the partial frame is abandoned. tx_valid drops asynchronously and no done is produced.

## Configuration
- FRAME_TX_CHECKSUM_EN defined:
  - CHK state is added after DATA.
  - tx_data in CHK = XOR of the 5 preceding bytes.
  - frames are 6 bytes.
- Undefined: frames are 5 bytes and CHK logic is absent.

## Structure
- Shared package frame_pkg holds:
  - SYNC_BYTE and the opcodes: 8'h06 host write, 8'h07 readback.
  - the state encoding.
  - the FRAME_LEN constant, 5 or 6 depending on FRAME_TX_CHECKSUM_EN.
- frame_pkg is also used by controller.
- One sub-module, frame_serializer: holds the output byte register and the valid/ready hold logic. The FSM supplies the next byte and a load strobe.

## Test plan
- base_addr=0, count=2, tx_ready=1, mem[0]=8'hA5, mem[1]=8'h3C:
  - bytes 19 07 00 00 A5 19 07 01 00 3C.
  - done 1 cycle after the last byte; 16 cycles in total.
- Same run with tx_ready toggling 1/0 every cycle: identical byte stream; tx_data stable whenever tx_valid=1 and tx_ready=0.
- base_addr=16'hFFFF, count=2: address bytes FF FF, then 00 00; mem_addr wraps to 0.
- count=0: done pulses 1 cycle after start; tx_valid and mem_en stay 0.
- Pulse start again during the second frame of count=3: exactly 15 bytes sent and one done.
- reset pulled low during ALO of frame 1:
  - all outputs 0 immediately, no done.
  - after release, start with count=1 gives a clean frame.
- With FRAME_TX_CHECKSUM_EN, base_addr=0, mem[0]=8'hA5: sixth byte = 19^07^00^00^A5 = 8'hBB.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared link framing constants and FSM encoding for the host byte link (frame_tx, controller).
// FRAME_TX_CHECKSUM_EN appends a one-byte XOR checksum, growing frames from 5 to 6 bytes.
package frame_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h19;
  localparam logic [7:0] OP_HOST_WR  = 8'h06;
  localparam logic [7:0] OP_READBACK = 8'h07;

`ifdef FRAME_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SYNC,
    S_OP,
    S_ALO,
    S_AHI,
    S_DATA,
    S_CHK,
    S_NEXT
  } state_t;

endpackage

// File: rtl/frame_serializer.sv
// Output byte register: load sets valid with a new byte, acceptance clears valid.
// Zero added latency; byte and valid hold steady while tx_ready is low.
module frame_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_dat,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_dat;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// Memory readback transmitter: one sync/op/addr/data frame per word; first byte 3 cycles after start,
// 8-cycle frame period at full rate; stalls on tx_ready low. FRAME_TX_CHECKSUM_EN adds a CHK byte.
module frame_tx #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SYNC_BYTE = frame_pkg::SYNC_BYTE,
  parameter logic [7:0] OPCODE    = frame_pkg::OP_READBACK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);
  import frame_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, remaining;
  logic [7:0]        data_reg;
  logic              accept, load, last_acc;
  logic [7:0]        load_dat;
`ifdef FRAME_TX_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  assign accept   = tx_valid && tx_ready;
  assign mem_addr = cur_addr;
  assign busy     = (state != S_IDLE);

  // Each byte is loaded on acceptance of the previous one, so the link sees back-to-back bytes.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    load      = 1'b0;
    load_dat  = '0;
    last_acc  = 1'b0;
    case (state)
      S_IDLE:  if (start && count != '0) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_en    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        load      = 1'b1;
        load_dat  = SYNC_BYTE;
        state_nxt = S_SYNC;
      end
      S_SYNC: if (accept) begin
        load      = 1'b1;
        load_dat  = OPCODE;
        state_nxt = S_OP;
      end
      S_OP: if (accept) begin
        load      = 1'b1;
        load_dat  = cur_addr[7:0];
        state_nxt = S_ALO;
      end
      S_ALO: if (accept) begin
        load      = 1'b1;
        load_dat  = cur_addr[15:8];
        state_nxt = S_AHI;
      end
      S_AHI: if (accept) begin
        load      = 1'b1;
        load_dat  = data_reg;
        state_nxt = S_DATA;
      end
`ifdef FRAME_TX_CHECKSUM_EN
      S_DATA: if (accept) begin
        load      = 1'b1;
        load_dat  = chk ^ tx_data;
        state_nxt = S_CHK;
      end
      S_CHK: if (accept) begin
        last_acc  = 1'b1;
        state_nxt = S_NEXT;
      end
`else
      S_DATA: if (accept) begin
        last_acc  = 1'b1;
        state_nxt = S_NEXT;
      end
`endif
      S_NEXT:  state_nxt = (remaining == ADDR_W'(1)) ? S_IDLE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      data_reg  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (last_acc && remaining == ADDR_W'(1)) ||
               (state == S_IDLE && start && count == '0);
      if (state == S_IDLE && start && count != '0) begin
        cur_addr  <= base_addr;
        remaining <= count;
      end
      if (state == S_WAIT) data_reg <= mem_data;
      if (state == S_NEXT) begin
        remaining <= remaining - ADDR_W'(1);
        cur_addr  <= cur_addr + ADDR_W'(1);
      end
    end
  end

`ifdef FRAME_TX_CHECKSUM_EN
  // Running XOR of accepted bytes; restarts with the sync byte of each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chk <= '0;
    else if (accept) chk <= (state == S_SYNC) ? tx_data : (chk ^ tx_data);
  end
`endif

  frame_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_dat (load_dat),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: byte streams, timing, backpressure, wrap, restart and reset abort.
// Honours FRAME_TX_CHECKSUM_EN for the expected frame contents.
module tb_frame_tx;
  import frame_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] ma_q[$];

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, first_me, first_tv, done_n, done_cyc, s_cyc;
  bit   mon_on = 0, busy_seen, hold_pend;
  logic [7:0] hold_dat;

  frame_tx dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (mem_en) begin
        if (first_me < 0) first_me = cyc;
        ma_q.push_back(mem_addr);
      end
      if (tx_valid && first_tv < 0) first_tv = cyc;
      if (busy) busy_seen = 1;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (hold_pend) begin
        check("hold_vld", {31'd0, tx_valid}, 32'd1);
        check("hold_dat", {24'd0, tx_data}, {24'd0, hold_dat});
      end
      hold_pend = tx_valid && !tx_ready;
      hold_dat  = tx_data;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
  end

  task automatic mon_clear();
    got_q.delete(); exp_q.delete(); ma_q.delete();
    first_me = -1; first_tv = -1; done_n = 0; done_cyc = -1;
    busy_seen = 0; hold_pend = 0; mon_on = 1;
  endtask

  task automatic add_frame(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] b [5];
    logic [7:0] x;
    b[0] = 8'h19; b[1] = 8'h07; b[2] = a[7:0]; b[3] = a[15:8]; b[4] = d;
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(b[i]);
      x = x ^ b[i];
    end
`ifdef FRAME_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic step(input bit tog);
    @(posedge clk);
    #1;
    tx_ready = tog ? ~tx_ready : 1'b1;
  endtask

  // Issues start at posedge+1; s_cyc is the monitor index of the cycle ending at the sampling edge.
  task automatic run(input logic [15:0] b, input logic [15:0] c, input bit tog, input int restart_at);
    bit restarted = 0;
    int k;
    mon_clear();
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    base_addr = b; count = c; start = 1'b1;
    s_cyc = cyc + 1;
    k = 0;
    while (done_n == 0 && k < 400) begin
      step(tog);
      start = 1'b0;
      base_addr = 16'h1234; count = 16'h0007;
      if (restart_at > 0 && !restarted && got_q.size() >= restart_at) begin
        start = 1'b1; base_addr = 16'd100; count = 16'd5; restarted = 1;
      end
      k++;
    end
    check("done_seen", {31'd0, done_n > 0}, 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0);
    start = 1'b0;
  endtask

  initial begin
    mem[16'h0000] = 8'hA5; mem[16'h0001] = 8'h3C;
    mem[16'hFFFF] = 8'h5A; mem[16'h0005] = 8'h77;
    mem[16'd10] = 8'h11; mem[16'd11] = 8'h22; mem[16'd12] = 8'h33;

    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", {31'd0, tx_valid}, 32'd0);
    check("rst_men", {31'd0, mem_en}, 32'd0);
    reset = 1'b1;
    step(1'b0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_addr", {16'd0, mem_addr}, 32'd0);
    check("idle_txd", {24'd0, tx_data}, 32'd0);

    // Two words at full rate: byte stream and cycle timing.
    run(16'h0000, 16'd2, 1'b0, 0);
    add_frame(16'h0000, 8'hA5); add_frame(16'h0001, 8'h3C);
    compare_stream("t1_byte");
    check("t1_memen_cyc", first_me - s_cyc, 32'd1);
    check("t1_valid_cyc", first_tv - s_cyc, 32'd3);
    check("t1_done_cyc", done_cyc - s_cyc, 32'd2 * FRAME_LEN + 32'd6);
    check("t1_done_n", done_n, 32'd1);
`ifdef FRAME_TX_CHECKSUM_EN
    check("t1_chk_byte", {24'd0, got_q[5]}, 32'hBB);
`endif

    // Same run under alternating backpressure.
    run(16'h0000, 16'd2, 1'b1, 0);
    add_frame(16'h0000, 8'hA5); add_frame(16'h0001, 8'h3C);
    compare_stream("t2_byte");
    check("t2_done_n", done_n, 32'd1);

    // Address wrap at the top of the space.
    run(16'hFFFF, 16'd2, 1'b0, 0);
    add_frame(16'hFFFF, 8'h5A); add_frame(16'h0000, 8'hA5);
    compare_stream("t3_byte");
    check("t3_ma_n", ma_q.size(), 32'd2);
    if (ma_q.size() == 2) check("t3_wrap_addr", {16'd0, ma_q[1]}, 32'd0);

    // Zero-length request.
    run(16'h0040, 16'd0, 1'b0, 0);
    check("t4_done_cyc", done_cyc - s_cyc, 32'd1);
    check("t4_nbytes", got_q.size(), 32'd0);
    check("t4_no_vld", first_tv, 32'hFFFF_FFFF);
    check("t4_no_memen", first_me, 32'hFFFF_FFFF);
    check("t4_busy", {31'd0, busy_seen}, 32'd0);

    // Start pulsed during the second of three frames must be ignored.
    run(16'd10, 16'd3, 1'b0, FRAME_LEN + 2);
    add_frame(16'd10, 8'h11); add_frame(16'd11, 8'h22); add_frame(16'd12, 8'h33);
    compare_stream("t5_byte");
    check("t5_done_n", done_n, 32'd1);

    // Reset during ALO of frame 1 abandons the frame.
    mon_clear();
    @(posedge clk);
    #1;
    base_addr = 16'h0000; count = 16'd2; start = 1'b1;
    step(1'b0);
    start = 1'b0;
    for (int k = 0; k < 40 && got_q.size() < 2; k++) step(1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_vld", {31'd0, tx_valid}, 32'd0);
    check("t6_txd", {24'd0, tx_data}, 32'd0);
    check("t6_memen", {31'd0, mem_en}, 32'd0);
    check("t6_addr", {16'd0, mem_addr}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    repeat (3) step(1'b0);
    reset = 1'b1;
    repeat (3) step(1'b0);
    check("t6_nbytes", got_q.size(), 32'd2);
    check("t6_done_n", done_n, 32'd0);
    run(16'h0005, 16'd1, 1'b0, 0);
    add_frame(16'h0005, 8'h77);
    compare_stream("t6_clean");
    check("t6_clean_done", done_n, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
